// File: rtl/core_mc.sv
// core_mc: multi-cycle RV32I/RV32E integer core.
// Each instruction walks FETCH -> WAIT -> DECODE -> EXEC, so a zero-wait
// instruction memory gives one retirement every four cycles. Illegal
// instructions and ECALL/EBREAK park the core in HALT until reset.
module core_mc #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          NUM_REGS      = 32,
  parameter bit          ENABLE_BRANCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        retire_valid,
  output logic [31:0] retire_pc,
  output logic [4:0]  retire_rd,
  output logic [31:0] retire_data,
  output logic        halted,
  output logic        illegal,
  input  logic [4:0]  dbg_rd_addr,
  output logic [31:0] dbg_rd_data
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

  // True when a register index exists in this configuration (RV32E has 16).
  function automatic logic reg_ok(input logic [4:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // Architectural and sequencing state
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] rs1_val_q, rs1_val_d;
  logic [31:0] rs2_val_q, rs2_val_d;
  logic [31:0] imm_q, imm_d;
  logic        started_q, started_d;
  logic        illegal_q, illegal_d;
  logic        retire_valid_q, retire_valid_d;
  logic [31:0] retire_pc_q, retire_pc_d;
  logic [4:0]  retire_rd_q, retire_rd_d;
  logic [31:0] retire_data_q, retire_data_d;

  // Register file (entry 0 is never written, so x0 always reads zero)
  logic [31:0] regs_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f, rs1_f, rs2_f;

  assign opcode = ir_q[6:0];
  assign rd_f   = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1_f  = ir_q[19:15];
  assign rs2_f  = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  // Register reads; indices outside the configured file read as zero
  logic [31:0] rs1_rdata, rs2_rdata;
  assign rs1_rdata   = (rs1_f == 5'd0 || !reg_ok(rs1_f)) ? 32'h0 : regs_q[rs1_f];
  assign rs2_rdata   = (rs2_f == 5'd0 || !reg_ok(rs2_f)) ? 32'h0 : regs_q[rs2_f];
  assign dbg_rd_data = (dbg_rd_addr == 5'd0 || !reg_ok(dbg_rd_addr))
                       ? 32'h0 : regs_q[dbg_rd_addr];

  // Immediate generation: sign-extend according to the instruction format
  logic [31:0] imm_dec;
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // through the case leaves it unassigned and infers a latch.
    imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
    case (opcode)
      OPC_STORE:  imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OPC_BRANCH: imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                             ir_q[11:8], 1'b0};
      OPC_LUI,
      OPC_AUIPC:  imm_dec = {ir_q[31:12], 12'h000};
      OPC_JAL:    imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                             ir_q[30:21], 1'b0};
      default:    imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  // ALU: register-register or register-immediate depending on opcode
  logic [31:0] op_a, op_b, alu_res;
  logic [4:0]  shamt;
  assign op_a  = rs1_val_q;
  assign op_b  = (opcode == OPC_OP) ? rs2_val_q : imm_q;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = 32'h0;
    case (funct3)
      3'b000: alu_res = (opcode == OPC_OP && funct7[5]) ? op_a - op_b : op_a + op_b;
      3'b001: alu_res = op_a << shamt;
      3'b010: alu_res = {31'h0, $signed(op_a) < $signed(op_b)};
      3'b011: alu_res = {31'h0, op_a < op_b};
      3'b100: alu_res = op_a ^ op_b;
      3'b101: alu_res = funct7[5] ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
      3'b110: alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

  // Branch condition from rs1/rs2
  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = rs1_val_q == rs2_val_q;
      3'b001:  br_taken = rs1_val_q != rs2_val_q;
      3'b100:  br_taken = $signed(rs1_val_q) <  $signed(rs2_val_q);
      3'b101:  br_taken = $signed(rs1_val_q) >= $signed(rs2_val_q);
      3'b110:  br_taken = rs1_val_q <  rs2_val_q;
      3'b111:  br_taken = rs1_val_q >= rs2_val_q;
      default: br_taken = 1'b0;
    endcase
  end

  // Execute-stage outcome: legality, result, write enable and next pc
  logic        ex_illegal, ex_sys, ex_wr;
  logic [31:0] ex_result, ex_next_pc;
  logic [31:0] pc_plus4, pc_target, jalr_sum, jalr_target;
  assign pc_plus4    = pc_q + 32'd4;
  assign pc_target   = pc_q + imm_q;
  assign jalr_sum    = rs1_val_q + imm_q;
  assign jalr_target = {jalr_sum[31:1], 1'b0};

  always_comb begin
    ex_illegal = 1'b0;
    ex_sys     = 1'b0;
    ex_wr      = 1'b0;
    ex_result  = alu_res;
    ex_next_pc = pc_plus4;
    case (opcode)
      OPC_OP: begin
        ex_wr = 1'b1;
        if (!(funct7 == F7_BASE ||
              (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))))
          ex_illegal = 1'b1;
        if (!reg_ok(rd_f) || !reg_ok(rs1_f) || !reg_ok(rs2_f))
          ex_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        ex_wr = 1'b1;
        if (funct3 == 3'b001 && funct7 != F7_BASE)
          ex_illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
          ex_illegal = 1'b1;
        if (!reg_ok(rd_f) || !reg_ok(rs1_f))
          ex_illegal = 1'b1;
      end
      OPC_LUI: begin
        ex_wr      = 1'b1;
        ex_result  = imm_q;
        ex_illegal = !reg_ok(rd_f);
      end
      OPC_AUIPC: begin
        ex_wr      = 1'b1;
        ex_result  = pc_target;
        ex_illegal = !reg_ok(rd_f);
      end
      OPC_JAL: begin
        ex_wr      = 1'b1;
        ex_result  = pc_plus4;
        ex_next_pc = pc_target;
        ex_illegal = !reg_ok(rd_f) || (pc_target[1:0] != 2'b00);
      end
      OPC_JALR: begin
        ex_wr      = 1'b1;
        ex_result  = pc_plus4;
        ex_next_pc = jalr_target;
        ex_illegal = (funct3 != 3'b000) || !reg_ok(rd_f) || !reg_ok(rs1_f) ||
                     jalr_target[1];
      end
      OPC_BRANCH: begin
        if (br_taken)
          ex_next_pc = pc_target;
        ex_illegal = !ENABLE_BRANCH || (funct3 == 3'b010) || (funct3 == 3'b011) ||
                     !reg_ok(rs1_f) || !reg_ok(rs2_f) ||
                     (br_taken && pc_target[1:0] != 2'b00);
      end
      OPC_SYSTEM: begin
        if (ir_q == INSN_ECALL || ir_q == INSN_EBREAK)
          ex_sys = 1'b1;
        else
          ex_illegal = 1'b1;
      end
      default: ex_illegal = 1'b1;
    endcase
  end

  // Main FSM: next state, datapath captures and retire/write-back control
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    rs1_val_d      = rs1_val_q;
    rs2_val_d      = rs2_val_q;
    imm_d          = imm_q;
    started_d      = 1'b1;
    illegal_d      = illegal_q;
    retire_valid_d = 1'b0;
    retire_pc_d    = retire_pc_q;
    retire_rd_d    = retire_rd_q;
    retire_data_d  = retire_data_q;
    rf_we          = 1'b0;
    rf_waddr       = rd_f;
    rf_wdata       = ex_result;

    case (state_q)
      ST_FETCH: begin
        if (imem_req_valid && imem_req_ready)
          state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          ir_d    = imem_rsp_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        imm_d     = imm_dec;
        rs1_val_d = rs1_rdata;
        rs2_val_d = rs2_rdata;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (ex_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (ex_sys) begin
          retire_valid_d = 1'b1;
          retire_pc_d    = pc_q;
          retire_rd_d    = 5'd0;
          retire_data_d  = 32'h0;
          state_d        = ST_HALT;
        end else begin
          retire_valid_d = 1'b1;
          retire_pc_d    = pc_q;
          retire_rd_d    = ex_wr ? rd_f : 5'd0;
          retire_data_d  = (ex_wr && rd_f != 5'd0) ? ex_result : 32'h0;
          rf_we          = ex_wr && (rd_f != 5'd0);
          pc_d           = ex_next_pc;
          state_d        = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // State register for FSM, pc, pipeline latches and retire outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FETCH;
      pc_q           <= RESET_PC;
      ir_q           <= 32'h0;
      rs1_val_q      <= 32'h0;
      rs2_val_q      <= 32'h0;
      imm_q          <= 32'h0;
      started_q      <= 1'b0;
      illegal_q      <= 1'b0;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= 32'h0;
      retire_rd_q    <= 5'd0;
      retire_data_q  <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples its pre-edge inputs regardless of statement order.
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      rs1_val_q      <= rs1_val_d;
      rs2_val_q      <= rs2_val_d;
      imm_q          <= imm_d;
      started_q      <= started_d;
      illegal_q      <= illegal_d;
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
      retire_rd_q    <= retire_rd_d;
      retire_data_q  <= retire_data_d;
    end
  end

  // Register file write port; entries beyond NUM_REGS are never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file must read zero after reset, so it is built
      // from resettable flops rather than an unreset RAM macro.
      for (int i = 0; i < 32; i++)
        regs_q[i] <= 32'h0;
    end else begin
      for (int i = 1; i < 32; i++)
        if (i < NUM_REGS && rf_we && rf_waddr == 5'(i))
          regs_q[i] <= rf_wdata;
    end
  end

  // The fetch request stays low through reset and rises on the first edge after.
  assign imem_req_valid = (state_q == ST_FETCH) && started_q;
  assign imem_req_addr  = pc_q;
  assign retire_valid   = retire_valid_q;
  assign retire_pc      = retire_pc_q;
  assign retire_rd      = retire_rd_q;
  assign retire_data    = retire_data_q;
  assign halted         = (state_q == ST_HALT);
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: directed bench for core_mc. Four instances cover the default
// configuration, ENABLE_BRANCH = 0, NUM_REGS = 16 and RESET_PC = 0x100.
module tb_core_mc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 18;
  localparam logic [31:0] BAD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rq_v   [4];
  logic [31:0] rq_a   [4];
  logic        rq_r   [4];
  logic        rs_v   [4];
  logic [31:0] rs_d   [4];
  logic        rt_v   [4];
  logic [31:0] rt_pc  [4];
  logic [4:0]  rt_rd  [4];
  logic [31:0] rt_dat [4];
  logic        hlt    [4];
  logic        ill    [4];
  logic [4:0]  dbg_a  [4];
  logic [31:0] dbg_d  [4];

  logic [31:0] mem [4][128];
  bit          auto_mode [4];
  bit          acc_f [4];
  logic [31:0] acc_a [4];
  int          ret_cnt [4];
  logic [31:0] lpc  [4][32];
  logic [31:0] ldat [4][32];
  logic [4:0]  lrd  [4][32];
  int          lcyc [4][32];
  int          cyc, rel_cyc;
  int          total, bad;
  vec_t        vecs [NV];

  core_mc u0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(rq_v[0]), .imem_req_addr(rq_a[0]), .imem_req_ready(rq_r[0]),
    .imem_rsp_valid(rs_v[0]), .imem_rsp_data(rs_d[0]),
    .retire_valid(rt_v[0]), .retire_pc(rt_pc[0]), .retire_rd(rt_rd[0]),
    .retire_data(rt_dat[0]), .halted(hlt[0]), .illegal(ill[0]),
    .dbg_rd_addr(dbg_a[0]), .dbg_rd_data(dbg_d[0])
  );

  core_mc #(.ENABLE_BRANCH(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(rq_v[1]), .imem_req_addr(rq_a[1]), .imem_req_ready(rq_r[1]),
    .imem_rsp_valid(rs_v[1]), .imem_rsp_data(rs_d[1]),
    .retire_valid(rt_v[1]), .retire_pc(rt_pc[1]), .retire_rd(rt_rd[1]),
    .retire_data(rt_dat[1]), .halted(hlt[1]), .illegal(ill[1]),
    .dbg_rd_addr(dbg_a[1]), .dbg_rd_data(dbg_d[1])
  );

  core_mc #(.NUM_REGS(16)) u2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(rq_v[2]), .imem_req_addr(rq_a[2]), .imem_req_ready(rq_r[2]),
    .imem_rsp_valid(rs_v[2]), .imem_rsp_data(rs_d[2]),
    .retire_valid(rt_v[2]), .retire_pc(rt_pc[2]), .retire_rd(rt_rd[2]),
    .retire_data(rt_dat[2]), .halted(hlt[2]), .illegal(ill[2]),
    .dbg_rd_addr(dbg_a[2]), .dbg_rd_data(dbg_d[2])
  );

  core_mc #(.RESET_PC(32'h0000_0100)) u3 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(rq_v[3]), .imem_req_addr(rq_a[3]), .imem_req_ready(rq_r[3]),
    .imem_rsp_valid(rs_v[3]), .imem_rsp_data(rs_d[3]),
    .retire_valid(rt_v[3]), .retire_pc(rt_pc[3]), .retire_rd(rt_rd[3]),
    .retire_data(rt_dat[3]), .halted(hlt[3]), .illegal(ill[3]),
    .dbg_rd_addr(dbg_a[3]), .dbg_rd_data(dbg_d[3])
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: log retirements, then play a zero-wait memory for auto instances.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (rt_v[i]) begin
        if (ret_cnt[i] < 32) begin
          lpc[i][ret_cnt[i]]  = rt_pc[i];
          lrd[i][ret_cnt[i]]  = rt_rd[i];
          ldat[i][ret_cnt[i]] = rt_dat[i];
          lcyc[i][ret_cnt[i]] = cyc;
        end
        ret_cnt[i]++;
      end
      if (auto_mode[i]) begin
        rs_v[i]  = acc_f[i];
        rs_d[i]  = acc_f[i] ? mem[i][acc_a[i][8:2]] : 32'h0;
        rq_r[i]  = rq_v[i];
        acc_f[i] = rq_v[i];
        acc_a[i] = rq_a[i];
      end
    end
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rq_r[i] = 1'b0; rs_v[i] = 1'b0; acc_f[i] = 1'b0; ret_cnt[i] = 0;
    end
    step();
    step();
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic run_until(input int d, input int budget, input string name);
    int n = 0;
    while (!hlt[d] && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(hlt[d]), 32'd1);
  endtask

  task automatic dbg_check(input int d, input logic [4:0] a, input logic [31:0] exp,
                           input string name);
    dbg_a[d] = a;
    #1;
    check(name, dbg_d[d], exp);
  endtask

  initial begin
    // pc, instruction, expected retire data, expected retire rd
    vecs[0]  = '{32'h00, 32'h0050_0093, 32'h0000_0005, 5'd1};   // ADDI x1,x0,5
    vecs[1]  = '{32'h04, 32'h0010_8133, 32'h0000_000A, 5'd2};   // ADD x2,x1,x1
    vecs[2]  = '{32'h08, 32'h0070_0013, 32'h0000_0000, 5'd0};   // ADDI x0,x0,7
    vecs[3]  = '{32'h0C, 32'h0010_0093, 32'h0000_0001, 5'd1};   // ADDI x1,x0,1
    vecs[4]  = '{32'h10, 32'h4010_01B3, 32'hFFFF_FFFF, 5'd3};   // SUB x3,x0,x1
    vecs[5]  = '{32'h14, 32'h4041_D213, 32'hFFFF_FFFF, 5'd4};   // SRAI x4,x3,4
    vecs[6]  = '{32'h18, 32'h01C1_D293, 32'h0000_000F, 5'd5};   // SRLI x5,x3,28
    vecs[7]  = '{32'h1C, 32'h0011_A333, 32'h0000_0001, 5'd6};   // SLT x6,x3,x1
    vecs[8]  = '{32'h20, 32'h0011_B3B3, 32'h0000_0000, 5'd7};   // SLTU x7,x3,x1
    vecs[9]  = '{32'h24, 32'h1234_5437, 32'h1234_5000, 5'd8};   // LUI x8,0x12345
    vecs[10] = '{32'h28, 32'h0000_1497, 32'h0000_1028, 5'd9};   // AUIPC x9,1
    vecs[11] = '{32'h2C, 32'h0F01_C513, 32'hFFFF_FF0F, 5'd10};  // XORI x10,x3,0xF0
    vecs[12] = '{32'h30, 32'h0000_9463, 32'h0000_0000, 5'd0};   // BNE x1,x0,+8
    vecs[13] = '{32'h38, 32'h0080_05EF, 32'h0000_003C, 5'd11};  // JAL x11,+8
    vecs[14] = '{32'h40, 32'h0105_8667, 32'h0000_0044, 5'd12};  // JALR x12,x11,16
    vecs[15] = '{32'h4C, 32'h0146_0667, 32'h0000_0050, 5'd12};  // JALR x12,x12,20
    vecs[16] = '{32'h58, 32'h00A0_9733, 32'h0000_8000, 5'd14};  // SLL x14,x1,x10
    vecs[17] = '{32'h5C, 32'h0000_0073, 32'h0000_0000, 5'd0};   // ECALL

    total = 0; bad = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 128; j++) mem[i][j] = BAD;
      rq_r[i] = 1'b0; rs_v[i] = 1'b0; rs_d[i] = 32'h0; dbg_a[i] = 5'd0;
      acc_f[i] = 1'b0; acc_a[i] = 32'h0; ret_cnt[i] = 0;
    end
    for (int k = 0; k < NV; k++) mem[0][vecs[k].pc[8:2]] = vecs[k].instr;
    mem[1][0] = 32'h0000_0463;   // BEQ x0,x0,+8 with branches disabled
    mem[2][0] = 32'h0010_0813;   // ADDI x16,x0,1 on RV32E
    auto_mode[0] = 1'b1; auto_mode[1] = 1'b1; auto_mode[2] = 1'b1; auto_mode[3] = 1'b0;

    // ---- Main program, plus illegal cases on the variant instances ----
    #2;
    check("reset_req_valid", 32'(rq_v[0]), 32'd0);
    check("reset_retire_valid", 32'(rt_v[0]), 32'd0);
    reset_all();
    run_until(0, 300, "prog_halted");
    repeat (3) step();

    check("prog_retire_count", 32'(ret_cnt[0]), 32'(NV));
    for (int k = 0; k < NV; k++) begin
      check($sformatf("retire_pc[%0d]", k), lpc[0][k], vecs[k].pc);
      check($sformatf("retire_rd[%0d]", k), 32'(lrd[0][k]), 32'(vecs[k].rd));
      check($sformatf("retire_data[%0d]", k), ldat[0][k], vecs[k].data);
    end
    check("first_retire_latency", 32'(lcyc[0][0] - rel_cyc), 32'd5);
    check("retire_spacing", 32'(lcyc[0][1] - lcyc[0][0]), 32'd4);
    check("ecall_illegal", 32'(ill[0]), 32'd0);
    check("ecall_pc_hold", rq_a[0], 32'h0000_005C);
    check("halt_req_low", 32'(rq_v[0]), 32'd0);
    dbg_check(0, 5'd2,  32'h0000_000A, "dbg_x2");
    dbg_check(0, 5'd0,  32'h0000_0000, "dbg_x0");
    dbg_check(0, 5'd3,  32'hFFFF_FFFF, "dbg_x3");
    dbg_check(0, 5'd12, 32'h0000_0050, "dbg_x12");

    check("nobranch_halted", 32'(hlt[1]), 32'd1);
    check("nobranch_illegal", 32'(ill[1]), 32'd1);
    check("nobranch_no_retire", 32'(ret_cnt[1]), 32'd0);
    check("nobranch_pc_hold", rq_a[1], 32'h0000_0000);
    check("rv32e_halted", 32'(hlt[2]), 32'd1);
    check("rv32e_illegal", 32'(ill[2]), 32'd1);
    check("rv32e_no_retire", 32'(ret_cnt[2]), 32'd0);
    check("rv32e_req_low", 32'(rq_v[2]), 32'd0);
    dbg_check(2, 5'd16, 32'h0000_0000, "rv32e_dbg_x16");

    // ---- Asynchronous reset, then reset while waiting for a response ----
    rst_n = 1'b0;
    #1;
    check("async_rst_halted", 32'(hlt[0]), 32'd0);
    check("async_rst_retire_pc", rt_pc[0], 32'h0000_0000);
    check("async_rst_illegal", 32'(ill[1]), 32'd0);
    check("async_rst_req_valid", 32'(rq_v[0]), 32'd0);
    dbg_check(0, 5'd2, 32'h0000_0000, "async_rst_regs");
    for (int i = 0; i < 4; i++) begin
      rq_r[i] = 1'b0; rs_v[i] = 1'b0; acc_f[i] = 1'b0; ret_cnt[i] = 0;
    end
    step();
    step();
    check("rst_req_low", 32'(rq_v[3]), 32'd0);
    rst_n = 1'b1;
    step();
    check("first_req_valid", 32'(rq_v[3]), 32'd1);
    check("first_req_addr", rq_a[3], 32'h0000_0100);
    rq_r[3] = 1'b1;
    step();
    rq_r[3] = 1'b0;
    check("wait_req_low", 32'(rq_v[3]), 32'd0);
    rst_n   = 1'b0;
    rs_v[3] = 1'b1;
    rs_d[3] = 32'h0050_0093;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("late_rsp_req_valid", 32'(rq_v[3]), 32'd1);
    check("late_rsp_req_addr", rq_a[3], 32'h0000_0100);
    rs_v[3] = 1'b0;
    repeat (8) step();
    check("late_rsp_no_retire", 32'(ret_cnt[3]), 32'd0);
    dbg_check(3, 5'd1, 32'h0000_0000, "late_rsp_no_write");

    // The same instance then runs normally from its reset vector.
    mem[3][64] = 32'h0050_0093;
    mem[3][65] = 32'h0000_0073;
    acc_f[3] = 1'b0;
    auto_mode[3] = 1'b1;
    run_until(3, 100, "rpc_halted");
    step();
    check("rpc_retire_count", 32'(ret_cnt[3]), 32'd2);
    check("rpc_retire_pc", lpc[3][0], 32'h0000_0100);
    check("rpc_retire_data", ldat[3][0], 32'h0000_0005);

    // ---- Taken BEQ at pc 0 redirects the next fetch to 8 ----
    for (int j = 0; j < 128; j++) mem[0][j] = BAD;
    mem[0][0] = 32'h0000_0463;
    mem[0][2] = 32'h0000_0073;
    reset_all();
    begin
      int n = 0;
      while (ret_cnt[0] < 1 && n < 40) begin
        step();
        n++;
      end
    end
    check("beq_retired", 32'(ret_cnt[0]), 32'd1);
    check("beq_next_addr", rq_a[0], 32'h0000_0008);
    check("beq_next_valid", 32'(rq_v[0]), 32'd1);
    run_until(0, 100, "beq_halted");
    step();
    check("beq_target_pc", lpc[0][1], 32'h0000_0008);

    // ---- All-ones word at pc 0x10 is illegal ----
    for (int j = 0; j < 128; j++) mem[0][j] = BAD;
    mem[0][0] = 32'h0050_0093;
    mem[0][1] = 32'h0070_0013;
    mem[0][2] = 32'h0070_0013;
    mem[0][3] = 32'h0070_0013;
    reset_all();
    run_until(0, 100, "ill_halted");
    repeat (5) step();
    check("ill_flag", 32'(ill[0]), 32'd1);
    check("ill_retire_count", 32'(ret_cnt[0]), 32'd4);
    check("ill_pc_hold", rq_a[0], 32'h0000_0010);
    check("ill_req_low", 32'(rq_v[0]), 32'd0);
    dbg_check(0, 5'd1, 32'h0000_0005, "ill_x1_kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_mc.md
CORE_MC -- requirements
Module: core_mc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NUM_REGS, default 32, integer register count (legal: 16 = RV32E, 32 = RV32I).
REQ-003 SHALL have parameter ENABLE_BRANCH, default 1, conditional branches legal when 1, illegal when 0.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request.
- imem_req_addr  output  32  fetch byte address.
- imem_req_ready  input  1  request accepted.
- imem_rsp_valid  input  1  instruction word valid.
- imem_rsp_data  input  32  instruction word.
- retire_valid  output  1  one-cycle retire pulse.
- retire_pc  output  32  PC of retired instruction.
- retire_rd  output  5  destination register.
- retire_data  output  32  value written, 0 when rd = x0.
- halted  output  1  core stopped.
- illegal  output  1  halt caused by illegal instruction.
- dbg_rd_addr  input  5  debug register index.
- dbg_rd_data  output  32  combinational register read, 0 for x0 or index >= NUM_REGS.

Function
REQ-006 SHALL be a multi-cycle FSM: FETCH, WAIT, DECODE, EXEC, HALT.
REQ-007 FETCH: imem_req_valid = 1, imem_req_addr = pc; addr SHALL stay stable until imem_req_ready; on ready -> WAIT.
REQ-008 WAIT: imem_req_valid = 0; on imem_rsp_valid capture imem_rsp_data into instruction register -> DECODE; rsp_valid in any other state SHALL be ignored.
REQ-009 DECODE: decode fields, sign-extend I/S/B/U/J immediates to 32 bits, read rs1/rs2 (x0 reads 0) -> EXEC.
REQ-010 EXEC: compute result, write rd unless rd = x0, update pc -> FETCH; retire_* SHALL be registered and valid for exactly one cycle, the cycle after EXEC.
REQ-011 Zero-wait memory (ready in FETCH, rsp in the cycle after acceptance) SHALL give one retirement every 4 cycles.
REQ-012 Supported: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND; ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; LUI AUIPC JAL JALR; BEQ BNE BLT BGE BLTU BGEU (ENABLE_BRANCH = 1).
REQ-013 Arithmetic SHALL be modulo 2^32; shift amount = low 5 bits; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned.
REQ-014 Sequential pc = pc + 4; JAL/branch taken pc = pc + imm; JALR pc = (rs1 + imm) & ~1; JAL/JALR write pc + 4 to rd.
REQ-015 Illegal instruction: unlisted opcode/funct3/funct7, SLLI/SRLI/SRAI with bad funct7, rs1/rs2/rd >= NUM_REGS, branch with ENABLE_BRANCH = 0, or taken jump/branch target with bits[1:0] != 0.
REQ-016 Illegal: no register write, no retire pulse, pc holds faulting address, -> HALT with halted = 1, illegal = 1.
REQ-017 ECALL (32'h0000_0073) / EBREAK (32'h0010_0073): retire with rd = 0, data = 0, pc unchanged, then HALT with halted = 1, illegal = 0.
REQ-018 HALT SHALL be left only by reset; imem_req_valid = 0 in HALT.
REQ-019 JALR with rd = rs1 SHALL use the pre-write rs1 value.

Reset
REQ-020 rst_n low SHALL immediately force state FETCH, pc = RESET_PC, all registers 0, retire_valid/halted/illegal 0, retire_pc/rd/data 0.
REQ-021 imem_req_valid SHALL be 0 while rst_n is low and SHALL rise on the first clock edge after release.
REQ-022 Reset in WAIT SHALL discard the pending response; a late rsp_valid after release (state FETCH) SHALL be ignored.

Verification
REQ-023 Fetch 32'h0050_0093 (ADDI x1,x0,5) then 32'h0010_8133 (ADD x2,x1,x1), zero-wait -> retires at pc 0 (rd 1, data 5) and pc 4 (rd 2, data 10) 4 cycles apart; dbg x2 = 10.
REQ-024 32'h0070_0013 (ADDI x0,x0,7) -> retire rd 0, data 0; dbg x0 = 0.
REQ-025 x1 = 1, then 32'h4010_01B3 (SUB x3,x0,x1) -> x3 = 32'hFFFF_FFFF; SRAI x4,x3,4 -> 32'hFFFF_FFFF; SRLI x5,x3,28 -> 32'h0000_000F.
REQ-026 At pc 0, 32'h0000_0463 (BEQ x0,x0,+8) -> next imem_req_addr 32'h0000_0008; with ENABLE_BRANCH = 0 -> halted = 1, illegal = 1, no retire.
REQ-027 32'hFFFF_FFFF at pc 0x10 -> halted = 1, illegal = 1, no register change, imem_req_valid stays 0; NUM_REGS = 16 with ADDI x16,x0,1 -> same.
REQ-028 rst_n pulsed low in WAIT, rsp_valid held through release, RESET_PC = 32'h0000_0100 -> no retire; first request addr 32'h0000_0100.
